ir_frame_rx: RTL and testbench
==============================

# ir_frame_rx

- APB3 slave that receives and decodes pulse-distance IR frames from a demodulating IR receiver module on the robot.
- Output is an active-low, idle-high `sensor` pin: low during a carrier burst.
- Shares PCLK and the APB bus with the motor/IR-beacon peripheral. It is the receive end of the IR link that peripheral transmits on.
- Delivers 32-bit frames to the processor through a data register with valid/overrun flags, an error counter and an interrupt line.

## Interface

Parameters (time in ticks; one tick = TICK_DIV cycles):

- TICK_DIV, 1000: PCLK cycles per tick (10 µs at 100 MHz).
- LEAD_MARK_MIN, 800: minimum leader mark.
- LEAD_SPACE_MIN, 400: minimum leader space.
- MARK_MAX, 100: maximum bit mark or stop mark.
- BIT_THRESH, 112: a bit space of at least this many ticks decodes as 1; shorter decodes as 0.
- TIMEOUT, 1000: maximum length of any mark or space.

Ports (reset is asynchronous, active-low):

- PCLK input 1: clock.
- PRESERN input 1: reset.
- PSEL, PENABLE, PWRITE input 1 each: APB3 control.
- PADDR input 32: only [7:0] is decoded.
- PWDATA input 32: write data.
- PRDATA output 32: read data; combinational, 0 when not reading.
- PREADY output 1: tied 1.
- PSLVERR output 1: tied 0.
- sensor input 1: asynchronous receiver output, active-low.
- IRQ output 1: equals the VALID flag.

## Operation

Synchronisation and timing base:

- `sensor` passes through a 2-flop synchroniser (both flops reset to 1). A third flop holds the previous synced value for edge detection.
- The tick prescaler runs only while EN=1.
- The duration counter is 16 bits, saturating. It clears on every synced edge and on every state change, and increments once per tick.

Registers (write/read access phase is PSEL&&PENABLE):

- 0x00 DATA (R): last frame, first-received bit in bit 0. A read clears VALID.
- 0x04 STATUS (R): [0] VALID, [1] BUSY (state≠IDLE), [2] OVERRUN, [15:8] ERRCNT, others 0.
- 0x08 CTRL (R/W): [0] EN. Writing 1 to [1] clears ERRCNT and OVERRUN; this bit is self-clearing and reads 0.
- Other offsets read 0; writes to them are ignored.

State machine (all transitions require EN=1; EN=0 forces IDLE, discards the partial frame, and does not count an error):

- IDLE: on a falling edge → LEAD_MARK.
- LEAD_MARK: on a rising edge, go to LEAD_SPACE if dur≥LEAD_MARK_MIN, otherwise error.
- LEAD_SPACE: on a falling edge, go to BIT_MARK with bitcnt=0 if dur≥LEAD_SPACE_MIN, otherwise error.
- BIT_MARK: on a rising edge → BIT_SPACE. dur>MARK_MAX while still low → error.
- BIT_SPACE: on a falling edge:
  - bit = (dur≥BIT_THRESH); shift the bit into shreg[31] (right shift); increment bitcnt.
  - On the 32nd bit: DATA←the completed shift value, VALID←1, OVERRUN←1 if VALID was already 1; go to STOP.
  - Otherwise go to BIT_MARK.
- STOP: on a rising edge → IDLE. dur>MARK_MAX → error.
- Timeout: dur>TIMEOUT in LEAD_MARK, LEAD_SPACE or BIT_SPACE → error.
- Error: ERRCNT increments, saturating at 255; go to IDLE. In IDLE a still-low input does not retrigger; the next falling edge is required.

Reset values:

- ERRCNT=0, VALID=0, OVERRUN=0, DATA=0, EN=0, state IDLE.
- PRDATA=0, IRQ=0, PREADY=1, PSLVERR=0.
- Reset asserted mid-frame: all of the above apply immediately; no partial data survives.

Simultaneous events:

- Frame completion in the same cycle as a DATA read: VALID ends at 1 (set wins) and OVERRUN is not set.
- Error in the same cycle as a CTRL clear: ERRCNT ends at 0 (clear wins).
- A DATA read in the same cycle as the 32nd bit returns the old DATA.

## Timing

- A pin edge is seen by the state machine 3 PCLK cycles later: 2 synchroniser cycles plus the edge-detect register.
- VALID and IRQ rise on the clock edge after that detection.
- Duration is quantised to ±1 tick.
- APB: zero wait states. Register updates take effect on the PCLK edge that ends the access phase.

## Test plan

For tests 1–5, EN=1; the bench may override parameters (e.g. TICK_DIV=10) for speed.

1. Leader 9000/4500 µs, then bits 0x00FF_A55A LSB-first (mark 560 µs; space 560 µs for 0, 1690 µs for 1), then a 560 µs stop mark → DATA=0x00FF_A55A, STATUS=0x1, IRQ=1. A DATA read returns that value and then STATUS=0x0.
2. Two valid frames 0x1 then 0x2 with no read between them → DATA=0x2, STATUS bits [2:0]=101.
3. Leader mark of 5 ms → ERRCNT=1 and state IDLE. A valid frame 0xDEADBEEF that follows decodes correctly.
4. Frame stalled high for 12 ms after 10 bits → ERRCNT increments, BUSY=0, VALID stays 0.
5. PRESERN pulsed low mid-frame → all reset values, including EN=0.
6. EN=0, then a valid frame → no decode, ERRCNT=0. Writing CTRL=0x2 afterwards clears ERRCNT and OVERRUN.

Source files
------------

// File: rtl/ir_frame_rx.sv
// ir_frame_rx: APB3 slave that receives pulse-distance IR frames from a demodulating
// IR receiver and delivers 32-bit words to software.
//
// Ports:
//   PCLK, PRESERN         clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE   APB3 control; PADDR[7:0] decoded
//   PWDATA / PRDATA       write data / combinational read data (0 when not reading)
//   PREADY, PSLVERR       tied 1 / tied 0 (zero wait states, no errors)
//   sensor                asynchronous receiver output, low during a carrier burst
//   IRQ                   mirrors the VALID flag
//
// Register map: 0x00 DATA (R, read clears VALID), 0x04 STATUS (R),
//               0x08 CTRL (R/W: [0] EN, [1] write-1 clears ERRCNT and OVERRUN).
module ir_frame_rx #(
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned LEAD_MARK_MIN  = 800,
    parameter int unsigned LEAD_SPACE_MIN = 400,
    parameter int unsigned MARK_MAX       = 100,
    parameter int unsigned BIT_THRESH     = 112,
    parameter int unsigned TIMEOUT        = 1000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        sensor,
    output logic        IRQ
);

    localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

    localparam logic [15:0] LeadMarkMin  = 16'(LEAD_MARK_MIN);
    localparam logic [15:0] LeadSpaceMin = 16'(LEAD_SPACE_MIN);
    localparam logic [15:0] MarkMax      = 16'(MARK_MAX);
    localparam logic [15:0] BitThresh    = 16'(BIT_THRESH);
    localparam logic [15:0] Timeout      = 16'(TIMEOUT);

    localparam logic [7:0] AddrData   = 8'h00;
    localparam logic [7:0] AddrStatus = 8'h04;
    localparam logic [7:0] AddrCtrl   = 8'h08;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStop
    } state_e;

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic              sync1_q, sync2_q, prev_q;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [15:0]       dur_q, dur_d;
    state_e            state_q, state_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [31:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        errcnt_q, errcnt_d;
    logic              en_q, en_d;

    // ---------------------------------------------------------------------------------------
    // Edge detection and tick base
    // ---------------------------------------------------------------------------------------
    logic fall, rise, tick;

    assign fall = prev_q & ~sync2_q;
    assign rise = ~prev_q & sync2_q;
    assign tick = en_q && (presc_q == PrescMax);

    always_comb begin
        presc_d = presc_q + PrescW'(1);
        if (!en_q || tick) begin
            presc_d = '0;
        end
    end

    // ---------------------------------------------------------------------------------------
    // APB decode
    // ---------------------------------------------------------------------------------------
    logic       access, rd_data, ctrl_wr, clr;
    logic [7:0] addr;

    assign addr    = PADDR[7:0];
    assign access  = PSEL && PENABLE;
    assign rd_data = access && !PWRITE && (addr == AddrData);
    assign ctrl_wr = access && PWRITE && (addr == AddrCtrl);
    assign clr     = ctrl_wr && PWDATA[1];

    always_comb begin
        PRDATA = 32'h0;
        if (access && !PWRITE) begin
            case (addr)
                AddrData:   PRDATA = data_q;
                AddrStatus: PRDATA = {16'h0, errcnt_q, 5'h0, overrun_q,
                                      (state_q != StIdle), valid_q};
                AddrCtrl:   PRDATA = {31'h0, en_q};
                default:    PRDATA = 32'h0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign IRQ     = valid_q;

    // ---------------------------------------------------------------------------------------
    // Frame decoder
    // ---------------------------------------------------------------------------------------
    logic        err, frame_done;
    logic [31:0] shifted;

    // First-received bit ends up in bit 0 after 32 right shifts.
    assign shifted = {(dur_q >= BitThresh), shreg_q[31:1]};

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        err        = 1'b0;
        frame_done = 1'b0;

        if (!en_q) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // Only a fresh falling edge starts a frame; a line left low after an
                    // error never retriggers.
                    if (fall) begin
                        state_d = StLeadMark;
                    end
                end
                StLeadMark: begin
                    if (rise) begin
                        if (dur_q >= LeadMarkMin) begin
                            state_d = StLeadSpace;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (dur_q > Timeout) begin
                        err = 1'b1;
                    end
                end
                StLeadSpace: begin
                    if (fall) begin
                        if (dur_q >= LeadSpaceMin) begin
                            state_d  = StBitMark;
                            bitcnt_d = 5'd0;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (dur_q > Timeout) begin
                        err = 1'b1;
                    end
                end
                StBitMark: begin
                    if (rise) begin
                        state_d = StBitSpace;
                    end else if (dur_q > MarkMax) begin
                        err = 1'b1;
                    end
                end
                StBitSpace: begin
                    if (fall) begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd31) begin
                            frame_done = 1'b1;
                            state_d    = StStop;
                        end else begin
                            state_d = StBitMark;
                        end
                    end else if (dur_q > Timeout) begin
                        err = 1'b1;
                    end
                end
                StStop: begin
                    if (rise) begin
                        state_d = StIdle;
                    end else if (dur_q > MarkMax) begin
                        err = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (err) begin
            state_d = StIdle;
        end
    end

    // Duration restarts on every edge and every state change; saturates at all-ones.
    always_comb begin
        dur_d = dur_q;
        if (fall || rise || (state_d != state_q)) begin
            dur_d = 16'h0;
        end else if (tick && (dur_q != 16'hFFFF)) begin
            dur_d = dur_q + 16'd1;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Software-visible registers
    // ---------------------------------------------------------------------------------------
    always_comb begin
        data_d    = frame_done ? shifted : data_q;
        en_d      = ctrl_wr ? PWDATA[0] : en_q;

        // A completing frame beats a simultaneous DATA read.
        valid_d = valid_q;
        if (frame_done) begin
            valid_d = 1'b1;
        end else if (rd_data) begin
            valid_d = 1'b0;
        end

        // The old frame only counts as lost if it was not read in this very cycle.
        overrun_d = overrun_q;
        if (clr) begin
            overrun_d = 1'b0;
        end else if (frame_done && valid_q && !rd_data) begin
            overrun_d = 1'b1;
        end

        errcnt_d = errcnt_q;
        if (clr) begin
            errcnt_d = 8'h0;
        end else if (err && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            presc_q   <= '0;
            dur_q     <= 16'h0;
            state_q   <= StIdle;
            bitcnt_q  <= 5'd0;
            shreg_q   <= 32'h0;
            data_q    <= 32'h0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            errcnt_q  <= 8'h0;
            en_q      <= 1'b0;
        end else begin
            sync1_q   <= sensor;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            presc_q   <= presc_d;
            dur_q     <= dur_d;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            errcnt_q  <= errcnt_d;
            en_q      <= en_d;
        end
    end

    logic unused_pins;
    assign unused_pins = ^{PADDR[31:8], PWDATA[31:2]};

endmodule

// File: tb/tb_ir_frame_rx.sv
// tb_ir_frame_rx: randomized frame traffic against a register-level model of ir_frame_rx.
// Timing parameters are scaled down (TICK_DIV=4, thresholds /10) so whole frames are short;
// pulse widths are drawn well clear of every threshold so quantisation cannot flip a result.
module tb_ir_frame_rx;

    localparam int unsigned TD  = 4;
    localparam int unsigned LMM = 80;
    localparam int unsigned LSM = 40;
    localparam int unsigned MM  = 10;
    localparam int unsigned BT  = 12;
    localparam int unsigned TO  = 100;

    logic        pclk = 1'b0;
    logic        presern = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        sensor = 1'b1;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (register level, frame granularity).
    logic        m_en    = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovr   = 1'b0;
    logic [7:0]  m_err   = 8'h0;
    logic [31:0] m_data  = 32'h0;

    ir_frame_rx #(
        .TICK_DIV      (TD),
        .LEAD_MARK_MIN (LMM),
        .LEAD_SPACE_MIN(LSM),
        .MARK_MAX      (MM),
        .BIT_THRESH    (BT),
        .TIMEOUT       (TO)
    ) dut (
        .PCLK   (pclk),
        .PRESERN(presern),
        .PSEL   (psel),
        .PENABLE(penable),
        .PWRITE (pwrite),
        .PADDR  (paddr),
        .PWDATA (pwdata),
        .PRDATA (prdata),
        .PREADY (pready),
        .PSLVERR(pslverr),
        .sensor (sensor),
        .IRQ    (irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- model --------------------------------------------------------------------------
    function automatic logic [31:0] status_exp(input logic busy);
        return {16'h0, m_err, 5'h0, m_ovr, busy, m_valid};
    endfunction

    task automatic model_frame(input logic [31:0] w);
        if (m_en) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = w;
        end
    endtask

    task automatic model_error();
        if (m_en && m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // ---- APB ----------------------------------------------------------------------------
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b1; paddr = {24'h0, a}; pwdata = d; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; pwrite = 1'b0; paddr = {24'h0, a}; penable = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        #1 d = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        apb_read(8'h04, d);
        check({tag, ".status"}, d, status_exp(1'b0));
        check({tag, ".irq"}, {31'h0, irq}, {31'h0, m_valid});
    endtask

    task automatic check_data(input string tag);
        logic [31:0] d;
        apb_read(8'h00, d);
        check({tag, ".data"}, d, m_data);
        m_valid = 1'b0;
    endtask

    // ---- sensor stimulus ----------------------------------------------------------------
    task automatic hold(input logic level, input int unsigned ticks);
        sensor = level;
        repeat (ticks * TD) @(posedge pclk);
        #1;
    endtask

    task automatic send_leader();
        hold(1'b0, $urandom_range(96, 84));
        hold(1'b1, $urandom_range(60, 44));
    endtask

    task automatic send_bit(input logic b, input int unsigned space_override);
        hold(1'b0, $urandom_range(8, 4));
        if (space_override != 0) hold(1'b1, space_override);
        else if (b) hold(1'b1, $urandom_range(24, 16));
        else hold(1'b1, $urandom_range(8, 4));
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_leader();
        for (int i = 0; i < 32; i++) send_bit(w[i], 0);
        hold(1'b0, $urandom_range(8, 4));
        hold(1'b1, 20);
        model_frame(w);
    endtask

    task automatic send_bad_leader();
        hold(1'b0, $urandom_range(60, 30));
        hold(1'b1, 20);
        model_error();
    endtask

    // Stall high for longer than TIMEOUT in the space of bit k-1.
    task automatic send_stalled(input int unsigned k);
        logic [31:0] w;
        w = $urandom;
        send_leader();
        for (int i = 0; i < int'(k); i++) send_bit(w[i], (i == int'(k) - 1) ? 130 : 0);
        hold(1'b1, 10);
        model_error();
    endtask

    // ---- sequence -----------------------------------------------------------------------
    initial begin
        logic [31:0] d;
        logic [31:0] w;
        int unsigned kind;

        repeat (3) @(posedge pclk);
        #1;
        check("rst.prdata", prdata, 32'h0);
        check("rst.irq", {31'h0, irq}, 32'h0);
        check("rst.pready", {31'h0, pready}, 32'h1);
        check("rst.pslverr", {31'h0, pslverr}, 32'h0);
        presern = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        check_status("rst");
        apb_read(8'h08, d);
        check("rst.ctrl", d, 32'h0);
        apb_read(8'h00, d);
        check("rst.data", d, 32'h0);
        apb_read(8'h40, d);
        check("rst.unmapped", d, 32'h0);

        apb_write(8'h08, 32'h1);
        m_en = 1'b1;
        apb_read(8'h08, d);
        check("en.ctrl", d, 32'h1);

        // 1: reference frame
        send_frame(32'h00FF_A55A);
        check_status("t1");
        check_data("t1");
        check_status("t1.after_read");

        // 2: overrun
        send_frame(32'h1);
        send_frame(32'h2);
        check_status("t2");
        check_data("t2");

        // 3: short leader, then a good frame
        send_bad_leader();
        check_status("t3.err");
        send_frame(32'hDEAD_BEEF);
        check_status("t3");
        check_data("t3");

        // 4: stall after 10 bits
        send_stalled(10);
        check_status("t4");

        // randomized traffic
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(3, 0);
            case (kind)
                0, 1: begin
                    w = $urandom;
                    send_frame(w);
                end
                2: send_bad_leader();
                default: send_stalled($urandom_range(31, 1));
            endcase
            check_status($sformatf("rnd%0d", it));
            if ($urandom_range(1, 0) == 1) check_data($sformatf("rnd%0d", it));
        end

        // 5: reset in the middle of a frame
        send_frame(32'h1234_5678);
        check_status("t5.pre");
        send_leader();
        send_bit(1'b0, 0);
        hold(1'b0, 4);
        hold(1'b1, 3);
        apb_read(8'h04, d);
        check("t5.busy", d, status_exp(1'b1));
        sensor  = 1'b0;
        presern = 1'b0;
        #3;
        check("t5.irq_in_reset", {31'h0, irq}, 32'h0);
        repeat (4) @(posedge pclk);
        #1;
        sensor = 1'b1;
        m_en = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_err = 8'h0; m_data = 32'h0;
        repeat (2) @(posedge pclk);
        #1;
        presern = 1'b1;
        repeat (8) @(posedge pclk);
        #1;
        check_status("t5");
        apb_read(8'h08, d);
        check("t5.ctrl", d, 32'h0);
        apb_read(8'h00, d);
        check("t5.data", d, 32'h0);

        // 6: disabled receiver ignores a frame; CTRL clear
        send_frame($urandom);
        check_status("t6.disabled");
        apb_read(8'h00, d);
        check("t6.data", d, 32'h0);
        apb_write(8'h08, 32'h1);
        m_en = 1'b1;
        send_bad_leader();
        send_frame(32'hA5A5_0F0F);
        send_frame(32'h5A5A_F0F0);
        check_status("t6.pre_clear");
        apb_write(8'h08, 32'h2);
        m_en = 1'b0; m_err = 8'h0; m_ovr = 1'b0;
        check_status("t6.cleared");
        apb_read(8'h08, d);
        check("t6.ctrl", d, 32'h0);
        check_data("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
